aes_key_schedule_seq: RTL
=========================

# aes_key_schedule_seq

Sequential, runtime-selectable AES key expansion engine for AES-128/192/256. It replaces the fully unrolled combinational schedule: one 32-bit word is computed per cycle with a single SubWord instance, and all round keys are held in an internal word buffer. Encrypt and decrypt datapaths fetch round keys through a registered read port.

## Interface
- MAX_NK, default 8: largest supported key length in words (4, 6 or 8). Sets the key width and the buffer depth, 4*(MAX_NK+7) words.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE or DONE.
- key_len  in  2  key length select: 00 = 128, 01 = 192, 10 = 256, 11 = invalid.
- key_in  in  32*MAX_NK  key, left-aligned; word0 sits at the MSBs, e.g. [255:224] when MAX_NK=8.
- zeroize  in  1  clears the buffer; active only with the macro, see Configuration.
- busy  out  1  high while expanding.
- done  out  1  level; high in DONE.
- err  out  1  one-cycle pulse on a rejected start.
- rd_en  in  1  read request.
- rd_idx  in  4  round-key index, 0..Nr.
- rd_data  out  128  round key rd_idx; words 4*idx..4*idx+3, first word at the MSBs.
- rd_valid  out  1  qualifies rd_data.

## Operation
- Key parameters: Nk = 4/6/8 and Nr = 10/12/14. Total words W = 4*(Nr+1) = 44/52/60.
- States: IDLE, EXPAND, DONE.
- **IDLE/DONE + start, valid key_len with Nk ≤ MAX_NK:**
  - latch Nk;
  - write key words 0..Nk-1 to the buffer;
  - set i = Nk, j = 0 (i mod Nk), rcon = 0x01;
  - go to EXPAND.
- **IDLE/DONE + start, invalid key_len (11, or Nk > MAX_NK):** pulse err, remain in the current state, buffer unchanged.
- **EXPAND, per cycle:**
  - temp = w[i-1].
  - If j == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon) (0x80 → 0x1B → 0x36).
  - Else if Nk == 8 and j == 4: temp = SubWord(temp).
  - Write w[i] = w[i-Nk] ^ temp, then i++ and j = (j == Nk-1) ? 0 : j+1.
  - After writing word W-1, go to DONE.
- **DONE:** done = 1 and the buffer holds all round keys. A new start restarts expansion and drops done.
- start is ignored while in EXPAND.
- **Read port:**
  - rd_en with rd_idx ≤ Nr and word 4*rd_idx+3 already written: next cycle rd_valid = 1 and rd_data = round key.
  - Any other read (index above Nr, not yet generated, or none latched since reset): rd_valid = 0, rd_data = 0.
  - This lets a round-pipelined consumer start fetching during EXPAND.

## Timing
- Reset values: busy, done, err, rd_valid = 0; rd_data = 0; state IDLE; i, j = 0; rcon = 0x01.
- Buffer contents are not reset.
- Assertion of rst_n mid-EXPAND aborts immediately. A new start is then required.
- If start is sampled at edge E0, done rises after edge E0 + (W − Nk): +40 for AES-128, +46 for AES-192, +52 for AES-256.
- busy is high from after E0 until the edge that sets done.
- Round key k is readable in the cycle after word 4k+3 is written.
  - AES-128 example: key 0 is readable right after E0, key 1 after E4.
- Read latency is 1 cycle. rd_en is honoured every cycle (full throughput).
- A read and a write to the same word in the same cycle return the old data; rd_valid is 0 for that read.
- err is registered and pulses in the cycle after the rejected start.

## Configuration
- Macro: AES_KS_ZEROIZE_EN.
- **Defined:**
  - zeroize in IDLE or DONE clears every buffer word to 0 in one cycle, clears done and returns to IDLE.
  - Afterwards, reads return rd_valid = 0 until the next expansion.
  - zeroize during EXPAND aborts the run, clears the buffer and goes to IDLE.
  - zeroize wins over a simultaneous start.
- **Undefined:** the zeroize port is ignored and the buffer has no clear logic.

## Test plan
- AES-128: key 2b7e151628aed2a6abf7158809cf4f3c, start → done after 40 cycles; rd_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 46 cycles; rd_idx=12 → e98ba06f448c773c8ecc720401002202.
- AES-256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 52 cycles; rd_idx=14 → fe4890d1e6188d0b046df344706c631e; rd_idx=15 → rd_valid=0.
- Streaming read: AES-128, rd_en every cycle with rd_idx tracking generation → rd_valid=1 for key k exactly one cycle after word 4k+3 is written; rd_valid=0 earlier.
- Error and abort:
  - key_len=11 → err pulse, state IDLE.
  - MAX_NK=4 with key_len=10 → err.
  - rst_n low at cycle 20 of an AES-256 run → all outputs at reset values; a re-start matches the vector above.
- With AES_KS_ZEROIZE_EN: zeroize after AES-128 done → done=0, and rd_idx=0 gives rd_valid=0 on the following cycle.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion: one word per cycle into a round-key buffer behind a registered read port.
// Optional buffer clear on zeroize is built when AES_KS_ZEROIZE_EN is defined.

module aes_key_schedule_seq #(
  parameter int unsigned MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           key_len,
  input  logic [32*MAX_NK-1:0] key_in,
  input  logic                 zeroize,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 rd_en,
  input  logic [3:0]           rd_idx,
  output logic [127:0]         rd_data,
  output logic                 rd_valid
);

  localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_e         state_q, state_d;
  logic [AW-1:0]  i_q, i_d;
  logic [2:0]     j_q, j_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     nk_q, nk_d;
  logic           err_d;
  logic           load_c, exp_we_c, zero_c;

  logic [31:0]    mem_q [DEPTH];

  logic [3:0]     nk_sel;
  logic           key_ok;
  logic [31:0]    w_prev, w_far, sub_in, sub_out, temp, w_new;
  logic [AW-1:0]  w_last;
  logic           last_j;
  logic [AW-1:0]  rd_base;
  logic           rd_hit;

  // Key-length decode and the single-word expansion datapath
  always_comb begin
    case (key_len)
      2'b00:   nk_sel = 4'd4;
      2'b01:   nk_sel = 4'd6;
      2'b10:   nk_sel = 4'd8;
      default: nk_sel = 4'd0;
    endcase
    key_ok  = (key_len != 2'b11) && (32'(nk_sel) <= MAX_NK);
    w_prev  = mem_q[i_q - AW'(1)];
    w_far   = mem_q[i_q - AW'(nk_q)];
    sub_in  = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);
    if (j_q == 3'd0)                         temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && j_q == 3'd4)    temp = sub_out;
    else                                     temp = w_prev;
    w_new   = w_far ^ temp;
    w_last  = AW'({2'b00, nk_q, 2'b00} + 8'd27);
    last_j  = ({1'b0, j_q} == nk_q - 4'd1);
  end

  // Next-state and control
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    rcon_d   = rcon_q;
    nk_d     = nk_q;
    err_d    = 1'b0;
    load_c   = 1'b0;
    exp_we_c = 1'b0;
    zero_c   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (key_ok) begin
            load_c  = 1'b1;
            nk_d    = nk_sel;
            i_d     = AW'(nk_sel);
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            state_d = ST_EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXPAND: begin
        exp_we_c = 1'b1;
        i_d      = i_q + AW'(1);
        j_d      = last_j ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == w_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef AES_KS_ZEROIZE_EN
    if (zeroize) begin
      state_d  = ST_IDLE;
      i_d      = '0;
      j_d      = 3'd0;
      rcon_d   = 8'h01;
      err_d    = 1'b0;
      load_c   = 1'b0;
      exp_we_c = 1'b0;
      zero_c   = 1'b1;
    end
`endif
  end

`ifndef AES_KS_ZEROIZE_EN
  logic unused_zeroize;
  assign unused_zeroize = zeroize;
`endif

  // A key is readable once its last word is below the write pointer; loads/clears hide the buffer
  assign rd_base = AW'({rd_idx, 2'b00});
  assign rd_hit  = rd_en && (AW'({rd_idx, 2'b11}) < i_q) && !load_c && !zero_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= 3'd0;
      rcon_q   <= 8'h01;
      nk_q     <= 4'd4;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      rcon_q   <= rcon_d;
      nk_q     <= nk_d;
      busy     <= (state_d == ST_EXPAND);
      done     <= (state_d == ST_DONE);
      err      <= err_d;
      rd_valid <= rd_hit;
      rd_data  <= rd_hit ? {mem_q[rd_base], mem_q[rd_base + AW'(1)],
                            mem_q[rd_base + AW'(2)], mem_q[rd_base + AW'(3)]} : '0;
    end
  end

  // Round-key buffer; contents survive reset
  always_ff @(posedge clk) begin
`ifdef AES_KS_ZEROIZE_EN
    if (zero_c) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem_q[AW'(k)] <= '0;
    end else
`endif
    if (load_c) begin
      for (int unsigned k = 0; k < MAX_NK; k++) begin
        if (k < 32'(nk_sel)) mem_q[AW'(k)] <= key_in[32*(MAX_NK-k)-1 -: 32];
      end
    end else if (exp_we_c) begin
      mem_q[i_q] <= w_new;
    end
  end

endmodule
